voice_mixer: RTL

Downstream neighbour of the ADSR envelope stage. Consumes the per-voice enveloped samples that ADSR emits as the voice controller steps voice_index. Sums one full sweep of voices into a frame total, applies a master attenuation shift, and saturates to 16 bits. Presents one mixed sample per frame to the DAC/serialiser stage over a valid/ready handshake.

---
 rtl/mixer_pkg.sv | 15 +
 rtl/mixer_shift_sat.sv | 32 +++
 rtl/voice_mixer.sv | 101 ++++++++++
 3 files changed

// File: rtl/mixer_pkg.sv
// rtl/mixer_pkg.sv - shared defaults, sample limits and state type for the voice mixer
package mixer_pkg;

    localparam int NUM_VOICES_DEF = 256;
    localparam int ACC_WIDTH_DEF  = 24;

    localparam logic signed [15:0] SAMPLE_MAX = 16'sd32767;
    localparam logic signed [15:0] SAMPLE_MIN = -16'sd32768;

    typedef enum logic {
        ACCUM = 1'b0,
        SCALE = 1'b1
    } mixer_state_t;

endpackage

// File: rtl/mixer_shift_sat.sv
// rtl/mixer_shift_sat.sv - master attenuation shift and 16-bit saturation of a frame sum
module mixer_shift_sat
    import mixer_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic signed [ACC_WIDTH-1:0] sum,
    input  logic        [3:0]           shift,
    output logic signed [15:0]          result,
    output logic                        clip
);

    localparam logic signed [ACC_WIDTH-1:0] HI = ACC_WIDTH'(SAMPLE_MAX);
    localparam logic signed [ACC_WIDTH-1:0] LO = ACC_WIDTH'(SAMPLE_MIN);

    logic signed [ACC_WIDTH-1:0] shifted;

    assign shifted = sum >>> shift;

    always_comb begin
        result = shifted[15:0];
        clip   = 1'b0;
        if (shifted > HI) begin
            result = SAMPLE_MAX;
            clip   = 1'b1;
        end else if (shifted < LO) begin
            result = SAMPLE_MIN;
            clip   = 1'b1;
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - sums one sweep of voice samples per frame and hands a saturated mix downstream
module voice_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic        [7:0]  voice_index,
    input  logic signed [15:0] sample_in,
    input  logic               sample_valid,
    input  logic        [3:0]  master_shift,
    output logic signed [15:0] out_sample,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               frame_done,
    output logic        [15:0] sat_count,
    output logic        [15:0] drop_count,
    output logic               seq_err
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_VOICES - 1);

    mixer_state_t                state;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum_reg;
    logic signed [ACC_WIDTH-1:0] sample_ext;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic        [7:0]           expected_idx;
    logic signed [15:0]          scaled;
    logic                        clip;
    logic                        frame_end;
    logic                        buf_free;

    assign sample_ext = ACC_WIDTH'(sample_in);
    // Voice 0 always opens a fresh frame, discarding any partial sweep.
    assign acc_next   = (voice_index == 8'd0) ? sample_ext : acc + sample_ext;
    assign frame_end  = sample_valid && (voice_index == LAST_IDX);
    assign buf_free   = !out_valid || out_ready;

    mixer_shift_sat #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_shift_sat (
        .sum   (sum_reg),
        .shift (master_shift),
        .result(scaled),
        .clip  (clip)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ACCUM;
            acc          <= '0;
            sum_reg      <= '0;
            expected_idx <= 8'd0;
            out_sample   <= '0;
            out_valid    <= 1'b0;
            frame_done   <= 1'b0;
            sat_count    <= 16'd0;
            drop_count   <= 16'd0;
            seq_err      <= 1'b0;
        end else begin
            frame_done <= frame_end;

            // Samples are taken in either state so nothing upstream is lost during SCALE.
            if (sample_valid) begin
                if (voice_index != expected_idx) begin
                    seq_err <= 1'b1;
                end
                if (frame_end) begin
                    sum_reg      <= acc_next;
                    acc          <= '0;
                    expected_idx <= 8'd0;
                end else begin
                    acc          <= acc_next;
                    expected_idx <= voice_index + 8'd1;
                end
            end

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (state == SCALE) begin
                if (clip && sat_count != 16'hFFFF) begin
                    sat_count <= sat_count + 16'd1;
                end
                if (buf_free) begin
                    out_sample <= scaled;
                    out_valid  <= 1'b1;
                end else if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end

            state <= frame_end ? SCALE : ACCUM;
        end
    end

endmodule
